cpu_io_bridge: RTL and testbench

- Host-side endpoint for the core's 32-bit memory-mapped I/O port pair, facing the opposite direction from the core.
- Outbound: watches the core's output port (CPUOut). Each change of value becomes one word in a FIFO, drained to a host over a valid/ready stream.
- Inbound: accepts host words over a valid/ready stream and holds the latest one on the core's input port (CPUIn).
- Sits at the top level, between risc_v and the board or testbench host.

---
 rtl/cpu_io_bridge_pkg.sv | 15 +
 rtl/cpu_io_bridge_sync_fifo.sv | 66 ++++++
 rtl/cpu_io_bridge.sv | 71 +++++++
 tb/tb_cpu_io_bridge.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_bridge_pkg.sv
// Shared constants for the CPU I/O bridge: port width, outbound FIFO depth
// and the pointer-width helper used by the FIFO.
package io_bridge_pkg;

    localparam int IO_WIDTH      = 32;
    localparam int IO_FIFO_DEPTH = 4;

    // Pointer width for a power-of-two depth; never less than one bit.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    localparam int IO_PTR_W = ptr_width(IO_FIFO_DEPTH);

endpackage

// File: rtl/cpu_io_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO. head_data shows the oldest word
// and reads as zero while empty; a push into a full FIFO lands only with a pop.
module sync_fifo
    import io_bridge_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_FIFO_DEPTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_COUNT);

    // When full, the slot freed by a same-cycle pop is reused by the push.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !Reset) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/cpu_io_bridge.sv
// Host-side endpoint for the core's memory-mapped I/O port pair: reports each
// change of cpu_out through a FIFO stream and holds the latest host word on cpu_in.
module cpu_io_bridge
    import io_bridge_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_FIFO_DEPTH
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] cpu_out,
    output logic [WIDTH-1:0] cpu_in,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic [WIDTH-1:0] rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             overflow
);

    // Streams: a word moves at a rising edge where valid && ready; valid never
    // waits on ready, and data is stable while valid is high and not yet taken.

    logic [WIDTH-1:0] prev;
    logic             primed;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             fifo_full;

    assign push     = primed && (cpu_out != prev);
    assign pop      = tx_valid && tx_ready;
    assign tx_valid = !fifo_empty;
    assign rx_ready = !Reset;

    sync_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .Reset    (Reset),
        .push     (push),
        .push_data(cpu_out),
        .pop      (pop),
        .head_data(tx_data),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    // The first edge out of reset only captures cpu_out, so the core's
    // power-on value is never reported as a change.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            prev     <= '0;
            primed   <= 1'b0;
            overflow <= 1'b0;
            cpu_in   <= '0;
        end else begin
            prev   <= cpu_out;
            primed <= 1'b1;
            if (push && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
            if (rx_valid && rx_ready) begin
                cpu_in <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Bench for cpu_io_bridge: directed vector table followed by randomized
// traffic checked against a queue-based reference model.
module tb_cpu_io_bridge;

    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic         CLK = 1'b0;
    logic         Reset;
    logic [W-1:0] cpu_out;
    logic [W-1:0] cpu_in;
    logic [W-1:0] tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         overflow;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    cpu_io_bridge #(.WIDTH(W), .DEPTH(DEPTH)) dut (
        .CLK     (CLK),
        .Reset   (Reset),
        .cpu_out (cpu_out),
        .cpu_in  (cpu_in),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .overflow(overflow)
    );

    typedef struct {
        logic         rst;
        logic [W-1:0] co;
        logic         rdy;
        logic         rv;
        logic [W-1:0] rd;
        logic         e_tv;
        logic [W-1:0] e_td;
        logic         e_ov;
        logic [W-1:0] e_ci;
    } vec_t;

    vec_t vq[$];

    // Reference model: the outbound FIFO is a plain queue of reported words.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_prev;
    logic         m_primed;
    logic         m_ov;
    logic [W-1:0] m_ci;

    task automatic check(input string name, input int idx, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got 0x%08h expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic [W-1:0] co, input logic rdy,
                              input logic rv, input logic [W-1:0] rd);
        if (rst) begin
            mq.delete();
            m_prev   = '0;
            m_primed = 1'b0;
            m_ov     = 1'b0;
            m_ci     = '0;
        end else begin
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (m_primed && co != m_prev) begin
                if (mq.size() < DEPTH) mq.push_back(co);
                else m_ov = 1'b1;
            end
            m_prev   = co;
            m_primed = 1'b1;
            if (rv) m_ci = rd;
        end
    endtask

    // Drive at the falling edge, let the rising edge act, sample 1 time unit later.
    task automatic apply(input logic rst, input logic [W-1:0] co, input logic rdy,
                         input logic rv, input logic [W-1:0] rd);
        @(negedge CLK);
        Reset    = rst;
        cpu_out  = co;
        tx_ready = rdy;
        rx_valid = rv;
        rx_data  = rd;
        model_step(rst, co, rdy, rv, rd);
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic rst, input logic [W-1:0] co, input logic rdy,
                       input logic rv, input logic [W-1:0] rd, input logic e_tv,
                       input logic [W-1:0] e_td, input logic e_ov, input logic [W-1:0] e_ci);
        vq.push_back('{rst, co, rdy, rv, rd, e_tv, e_td, e_ov, e_ci});
    endtask

    initial begin
        Reset    = 1'b1;
        cpu_out  = '0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;

        //  rst co          rdy rv rd             tv  td          ov  ci
        add(1, 32'h5,       0,  0, 32'h0,         0,  32'h0,      0,  32'h0);
        add(0, 32'h5,       0,  0, 32'h0,         0,  32'h0,      0,  32'h0);
        for (int i = 0; i < 9; i++)
            add(0, 32'h5,   0,  0, 32'h0,         0,  32'h0,      0,  32'h0);
        add(0, 32'hA,       1,  0, 32'h0,         1,  32'hA,      0,  32'h0);
        add(0, 32'hA,       1,  0, 32'h0,         0,  32'h0,      0,  32'h0);
        add(0, 32'h1,       0,  0, 32'h0,         1,  32'h1,      0,  32'h0);
        add(0, 32'h2,       0,  0, 32'h0,         1,  32'h1,      0,  32'h0);
        add(0, 32'h3,       0,  0, 32'h0,         1,  32'h1,      0,  32'h0);
        add(0, 32'h4,       0,  0, 32'h0,         1,  32'h1,      0,  32'h0);
        add(0, 32'h5,       0,  0, 32'h0,         1,  32'h1,      1,  32'h0);
        add(0, 32'h5,       1,  0, 32'h0,         1,  32'h2,      1,  32'h0);
        add(0, 32'h5,       1,  0, 32'h0,         1,  32'h3,      1,  32'h0);
        add(0, 32'h5,       1,  0, 32'h0,         1,  32'h4,      1,  32'h0);
        add(0, 32'h5,       1,  0, 32'h0,         0,  32'h0,      1,  32'h0);
        add(0, 32'h1,       0,  0, 32'h0,         1,  32'h1,      1,  32'h0);
        add(0, 32'h2,       0,  0, 32'h0,         1,  32'h1,      1,  32'h0);
        add(0, 32'h3,       0,  0, 32'h0,         1,  32'h1,      1,  32'h0);
        add(0, 32'h4,       0,  0, 32'h0,         1,  32'h1,      1,  32'h0);
        add(0, 32'h9,       1,  0, 32'h0,         1,  32'h2,      1,  32'h0);
        add(0, 32'h9,       1,  0, 32'h0,         1,  32'h3,      1,  32'h0);
        add(0, 32'h9,       1,  0, 32'h0,         1,  32'h4,      1,  32'h0);
        add(0, 32'h9,       1,  0, 32'h0,         1,  32'h9,      1,  32'h0);
        add(0, 32'h9,       1,  0, 32'h0,         0,  32'h0,      1,  32'h0);
        add(0, 32'h9,       0,  1, 32'hDEADBEEF,  0,  32'h0,      1,  32'hDEADBEEF);
        add(0, 32'h9,       0,  1, 32'h12345678,  0,  32'h0,      1,  32'h12345678);
        add(0, 32'h9,       0,  0, 32'hFFFFFFFF,  0,  32'h0,      1,  32'h12345678);
        add(0, 32'h9,       0,  0, 32'h0,         0,  32'h0,      1,  32'h12345678);
        add(0, 32'h1,       0,  1, 32'h77,        1,  32'h1,      1,  32'h77);
        add(0, 32'h2,       0,  0, 32'h0,         1,  32'h1,      1,  32'h77);
        add(0, 32'h3,       0,  0, 32'h0,         1,  32'h1,      1,  32'h77);
        add(1, 32'h3,       1,  1, 32'hAA,        0,  32'h0,      0,  32'h0);
        add(0, 32'h7,       0,  0, 32'h0,         0,  32'h0,      0,  32'h0);
        add(0, 32'h7,       0,  0, 32'h0,         0,  32'h0,      0,  32'h0);
        add(0, 32'h8,       0,  0, 32'h0,         1,  32'h8,      0,  32'h0);
        add(0, 32'h6,       1,  1, 32'h55,        1,  32'h6,      0,  32'h55);
        add(0, 32'h6,       1,  0, 32'h0,         0,  32'h0,      0,  32'h55);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].rst, vq[i].co, vq[i].rdy, vq[i].rv, vq[i].rd);
            check("vec_tx_valid", i, W'(tx_valid), W'(vq[i].e_tv));
            check("vec_tx_data",  i, tx_data,      vq[i].e_td);
            check("vec_overflow", i, W'(overflow), W'(vq[i].e_ov));
            check("vec_cpu_in",   i, cpu_in,       vq[i].e_ci);
            check("vec_rx_ready", i, W'(rx_ready), W'(!vq[i].rst));
        end

        apply(1'b1, '0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 2000; i++) begin
            logic         r_rst;
            logic [W-1:0] r_co;
            logic         r_rdy;
            logic         r_rv;
            logic [W-1:0] r_rd;
            r_rst = ($urandom_range(0, 99) == 0);
            r_co  = W'($urandom_range(0, 3));
            r_rdy = ($urandom_range(0, 3) == 0);
            r_rv  = $urandom_range(0, 1) == 1;
            r_rd  = $urandom;
            apply(r_rst, r_co, r_rdy, r_rv, r_rd);
            check("rnd_tx_valid", i, W'(tx_valid), W'(mq.size() != 0));
            check("rnd_tx_data",  i, tx_data,      (mq.size() != 0) ? mq[0] : '0);
            check("rnd_overflow", i, W'(overflow), W'(m_ov));
            check("rnd_cpu_in",   i, cpu_in,       m_ci);
            check("rnd_rx_ready", i, W'(rx_ready), W'(!r_rst));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
